cook_sequencer: RTL and testbench

//  Top-level sequencer for the microwave datapath. Owns the cook FSM: gates keypad entry into the BCD timer,

---
 rtl/cook_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_cook_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cook_sequencer.sv
// cook_sequencer: microwave cook FSM. Gates keypad digits into the BCD timer,
// runs/pauses/stops the countdown, duty-cycles the magnetron by power level and
// drives the end-of-cook beep. All outputs are registered.
// Optional feature: define QUICK_START_EN to let start in IDLE load 0:30 and cook.
module cook_sequencer #(
    parameter int POWER_DEFAULT  = 10,
    parameter int DONE_BEEP_SECS = 3,
    parameter int MAX_DIGITS     = 3
) (
    input  logic       clock,
    input  logic       clearn,
    input  logic [9:0] keypad,
    input  logic       startn,
    input  logic       stopn,
    input  logic       powern,
    input  logic       door_closed,
    input  logic       tick_1hz,
    input  logic       timer_zero,
    output logic [3:0] digit_bcd,
    output logic       digit_loadn,
    output logic       timer_clearn,
    output logic       timer_en,
    output logic       mag_on,
    output logic [3:0] power_level,
    output logic       done_beep,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ENTRY  = 3'd1,
        S_COOK   = 3'd2,
        S_PAUSED = 3'd3,
        S_DONE   = 3'd4,
        S_QLOAD  = 3'd5
    } state_t;

    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int BW = (DONE_BEEP_SECS > 1) ? $clog2(DONE_BEEP_SECS) : 1;

    state_t          cur_state;
    logic [CW-1:0]   digit_count;
    logic [3:0]      duty_cnt;
    logic [BW-1:0]   beep_cnt;
    logic            prev_startn;
    logic            prev_stopn;
    logic            prev_powern;
    logic [9:0]      prev_keypad;
`ifdef QUICK_START_EN
    logic [1:0]      qload_step;
`endif

    logic            start_ev;
    logic            stop_ev;
    logic            power_ev;
    logic            key_ev;
    logic            key_onehot;
    logic [3:0]      key_digit;
    logic [3:0]      next_power;

    assign state = cur_state;

    // Edge detection on the sampled front-panel inputs and keypad decode.
    always_comb begin
        key_digit = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (keypad[i]) key_digit = 4'(i);
        end
        key_onehot = (keypad != '0) && ((keypad & (keypad - 10'd1)) == '0);
        key_ev     = key_onehot && (prev_keypad == '0);
        start_ev   = prev_startn && !startn;
        stop_ev    = prev_stopn  && !stopn;
        power_ev   = prev_powern && !powern;
        next_power = (power_level <= 4'd1) ? 4'd10 : power_level - 4'd1;
    end

    // Cook FSM; each state branch tests events in stop > door > timer_zero > start > power > key order.
    always_ff @(posedge clock) begin
        if (!clearn) begin
            cur_state    <= S_IDLE;
            power_level  <= 4'(POWER_DEFAULT);
            digit_count  <= '0;
            duty_cnt     <= '0;
            beep_cnt     <= '0;
            digit_bcd    <= '0;
            digit_loadn  <= 1'b1;
            timer_clearn <= 1'b0;
            timer_en     <= 1'b0;
            mag_on       <= 1'b0;
            done_beep    <= 1'b0;
            prev_startn  <= 1'b1;
            prev_stopn   <= 1'b1;
            prev_powern  <= 1'b1;
            prev_keypad  <= '0;
`ifdef QUICK_START_EN
            qload_step   <= '0;
`endif
        end else begin
            prev_startn  <= startn;
            prev_stopn   <= stopn;
            prev_powern  <= powern;
            prev_keypad  <= keypad;
            digit_loadn  <= 1'b1;
            timer_clearn <= 1'b1;
            case (cur_state)
                S_IDLE: begin
`ifdef QUICK_START_EN
                    if (start_ev && door_closed) begin
                        cur_state  <= S_QLOAD;
                        qload_step <= '0;
                    end else
`endif
                    if (power_ev) begin
                        power_level <= next_power;
                    end else if (key_ev) begin
                        digit_bcd   <= key_digit;
                        digit_loadn <= 1'b0;
                        digit_count <= digit_count + 1'b1;
                        cur_state   <= S_ENTRY;
                    end
                end
                S_ENTRY: begin
                    if (stop_ev) begin
                        cur_state    <= S_IDLE;
                        timer_clearn <= 1'b0;
                        digit_count  <= '0;
                    end else if (start_ev && door_closed) begin
                        cur_state <= S_COOK;
                        duty_cnt  <= '0;
                        timer_en  <= 1'b1;
                        mag_on    <= (power_level != 4'd0);
                    end else if (power_ev) begin
                        power_level <= next_power;
                    end else if (key_ev && (digit_count < CW'(MAX_DIGITS))) begin
                        digit_bcd   <= key_digit;
                        digit_loadn <= 1'b0;
                        digit_count <= digit_count + 1'b1;
                    end
                end
                S_COOK: begin
                    if (stop_ev || !door_closed) begin
                        cur_state <= S_PAUSED;
                        timer_en  <= 1'b0;
                        mag_on    <= 1'b0;
                    end else if (timer_zero) begin
                        cur_state <= S_DONE;
                        beep_cnt  <= '0;
                        done_beep <= 1'b1;
                        timer_en  <= 1'b0;
                        mag_on    <= 1'b0;
                    end else begin
                        // mag_on follows the pre-tick duty value, so it lags a duty step by one cycle.
                        mag_on <= (duty_cnt < power_level);
                        if (tick_1hz) duty_cnt <= (duty_cnt == 4'd9) ? 4'd0 : duty_cnt + 4'd1;
                    end
                end
                S_PAUSED: begin
                    if (stop_ev) begin
                        cur_state    <= S_IDLE;
                        timer_clearn <= 1'b0;
                        digit_count  <= '0;
                    end else if (start_ev && door_closed) begin
                        cur_state <= S_COOK;
                        timer_en  <= 1'b1;
                        mag_on    <= (duty_cnt < power_level);
                    end
                end
                S_DONE: begin
                    if (stop_ev || key_ev || !door_closed) begin
                        cur_state   <= S_IDLE;
                        done_beep   <= 1'b0;
                        digit_count <= '0;
                    end else if (tick_1hz) begin
                        if (beep_cnt == BW'(DONE_BEEP_SECS - 1)) begin
                            cur_state   <= S_IDLE;
                            done_beep   <= 1'b0;
                            digit_count <= '0;
                        end else begin
                            beep_cnt <= beep_cnt + 1'b1;
                        end
                    end
                end
`ifdef QUICK_START_EN
                S_QLOAD: begin
                    case (qload_step)
                        2'd0: begin
                            digit_bcd   <= 4'd3;
                            digit_loadn <= 1'b0;
                            qload_step  <= 2'd1;
                        end
                        2'd1: begin
                            digit_bcd   <= 4'd0;
                            digit_loadn <= 1'b0;
                            qload_step  <= 2'd2;
                        end
                        default: begin
                            cur_state <= S_COOK;
                            duty_cnt  <= '0;
                            timer_en  <= 1'b1;
                            mag_on    <= door_closed && (power_level != 4'd0);
                        end
                    endcase
                end
`endif
                default: cur_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cook_sequencer.sv
// tb_cook_sequencer: directed scenarios plus a randomized soak, every cycle
// compared against a behavioural model of the cook sequencer rules.
module tb_cook_sequencer;

    localparam int POWER_DEFAULT  = 10;
    localparam int DONE_BEEP_SECS = 3;
    localparam int MAX_DIGITS     = 3;
`ifdef QUICK_START_EN
    localparam bit QS = 1'b1;
`else
    localparam bit QS = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       clearn;
    logic [9:0] keypad;
    logic       startn, stopn, powern, door_closed, tick_1hz, timer_zero;
    logic [3:0] digit_bcd;
    logic       digit_loadn, timer_clearn, timer_en, mag_on, done_beep;
    logic [3:0] power_level;
    logic [2:0] state;

    always #5 clock = ~clock;

    cook_sequencer #(
        .POWER_DEFAULT  (POWER_DEFAULT),
        .DONE_BEEP_SECS (DONE_BEEP_SECS),
        .MAX_DIGITS     (MAX_DIGITS)
    ) dut (
        .clock        (clock),
        .clearn       (clearn),
        .keypad       (keypad),
        .startn       (startn),
        .stopn        (stopn),
        .powern       (powern),
        .door_closed  (door_closed),
        .tick_1hz     (tick_1hz),
        .timer_zero   (timer_zero),
        .digit_bcd    (digit_bcd),
        .digit_loadn  (digit_loadn),
        .timer_clearn (timer_clearn),
        .timer_en     (timer_en),
        .mag_on       (mag_on),
        .power_level  (power_level),
        .done_beep    (done_beep),
        .state        (state)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: numeric states 0..5 as listed for the state output.
    int m_state, m_power, m_digits, m_duty, m_beep, m_q;
    int e_digit, e_loadn, e_clearn, e_ten, e_mag, e_done;
    logic p_start, p_stop, p_power;
    logic [9:0] p_key;
    int loads[$];

    function automatic int key_value(input logic [9:0] k, input logic [9:0] prev);
        if (prev != 0 || $countones(k) != 1) return -1;
        for (int i = 0; i < 10; i++) if (k[i]) return i;
        return -1;
    endfunction

    function automatic void go_idle();
        m_state = 0;
        m_digits = 0;
        e_ten = 0;
        e_mag = 0;
        e_done = 0;
    endfunction

    function automatic void enter_cook();
        m_state = 2;
        e_ten = 1;
        e_mag = (m_duty < m_power && door_closed) ? 1 : 0;
    endfunction

    function automatic void model_edge();
        bit s, t, p;
        int kd;
        if (!clearn) begin
            m_state = 0; m_power = POWER_DEFAULT; m_digits = 0; m_duty = 0; m_beep = 0; m_q = 0;
            e_digit = 0; e_loadn = 1; e_clearn = 0; e_ten = 0; e_mag = 0; e_done = 0;
            p_start = 1; p_stop = 1; p_power = 1; p_key = '0;
            return;
        end
        s = p_stop && !stopn;
        t = p_start && !startn;
        p = p_power && !powern;
        kd = key_value(keypad, p_key);
        e_loadn = 1;
        e_clearn = 1;
        case (m_state)
            0: begin
                if (QS && t && door_closed) begin m_state = 5; m_q = 0; end
                else if (p) m_power = (m_power == 1) ? 10 : m_power - 1;
                else if (kd >= 0) begin e_digit = kd; e_loadn = 0; m_digits++; m_state = 1; end
            end
            1: begin
                if (s) begin go_idle(); e_clearn = 0; end
                else if (t && door_closed) begin m_duty = 0; enter_cook(); end
                else if (p) m_power = (m_power == 1) ? 10 : m_power - 1;
                else if (kd >= 0 && m_digits < MAX_DIGITS) begin e_digit = kd; e_loadn = 0; m_digits++; end
            end
            2: begin
                if (s || !door_closed) begin m_state = 3; e_ten = 0; e_mag = 0; end
                else if (timer_zero) begin m_state = 4; m_beep = 0; e_done = 1; e_ten = 0; e_mag = 0; end
                else begin
                    e_mag = (m_duty < m_power) ? 1 : 0;
                    if (tick_1hz) m_duty = (m_duty + 1) % 10;
                end
            end
            3: begin
                if (s) begin go_idle(); e_clearn = 0; end
                else if (t && door_closed) enter_cook();
            end
            4: begin
                if (s || kd >= 0 || !door_closed) go_idle();
                else if (tick_1hz) begin
                    m_beep++;
                    if (m_beep == DONE_BEEP_SECS) go_idle();
                end
            end
            5: begin
                if (m_q == 0) begin e_digit = 3; e_loadn = 0; m_q = 1; end
                else if (m_q == 1) begin e_digit = 0; e_loadn = 0; m_q = 2; end
                else begin m_duty = 0; enter_cook(); end
            end
            default: ;
        endcase
        p_start = startn; p_stop = stopn; p_power = powern; p_key = keypad;
    endfunction

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check("state",        state,        m_state);
        check("power_level",  power_level,  m_power);
        check("digit_loadn",  digit_loadn,  e_loadn);
        check("digit_bcd",    digit_bcd,    e_digit);
        check("timer_clearn", timer_clearn, e_clearn);
        check("timer_en",     timer_en,     e_ten);
        check("mag_on",       mag_on,       e_mag);
        check("done_beep",    done_beep,    e_done);
        if (digit_loadn === 1'b0) loads.push_back(int'(digit_bcd));
    endtask

    task automatic press_key(input int d);
        keypad = 10'b1 << d; step();
        keypad = '0;         step();
    endtask
    task automatic press_start(); startn = 0; step(); startn = 1; step(); endtask
    task automatic press_stop();  stopn  = 0; step(); stopn  = 1; step(); endtask
    task automatic press_power(); powern = 0; step(); powern = 1; step(); endtask
    task automatic do_tick(input int gap);
        tick_1hz = 1; step();
        tick_1hz = 0; repeat (gap) step();
    endtask

    initial begin
        int mag_count;
        clearn = 0; keypad = '0; startn = 1; stopn = 1; powern = 1;
        door_closed = 1; tick_1hz = 0; timer_zero = 0;

        // Reset held two cycles
        repeat (2) step();
        check("rst_state", state, 0);
        check("rst_power", power_level, 10);
        check("rst_clearn", timer_clearn, 0);
        check("rst_loadn", digit_loadn, 1);
        check("rst_mag", mag_on, 0);
        clearn = 1; step();
        check("rel_clearn", timer_clearn, 1);

        // Keys 1,3,0 accepted, 4th key ignored
        loads.delete();
        press_key(1); press_key(3); press_key(0); press_key(5);
        check("entry_loads", loads.size(), 3);
        if (loads.size() == 3) begin
            check("entry_d0", loads[0], 1);
            check("entry_d1", loads[1], 3);
            check("entry_d2", loads[2], 0);
        end
        check("entry_state", state, 1);
        press_stop();
        check("stop_idle", state, 0);

        // Power 7, cook, duty pattern
        repeat (3) press_power();
        press_key(0); press_key(5);
        press_start();
        check("cook_state", state, 2);
        check("cook_power", power_level, 7);
        mag_count = 0;
        for (int i = 0; i < 10; i++) begin
            do_tick($urandom_range(2, 5));
            if (mag_on === 1'b1) mag_count++;
        end
        check("duty_7_of_10", mag_count, 7);

        // Door open at duty 4, resume keeps duty
        repeat (4) do_tick($urandom_range(2, 4));
        door_closed = 0; step();
        check("pause_state", state, 3);
        check("pause_mag", mag_on, 0);
        check("pause_ten", timer_en, 0);
        door_closed = 1; step();
        press_start();
        check("resume_state", state, 2);
        check("resume_mag_d4", mag_on, 1);
        do_tick(2); do_tick(2);
        check("resume_mag_d6", mag_on, 1);
        do_tick(2);
        check("resume_mag_d7", mag_on, 0);

        // timer_zero with tick -> DONE, beep for three ticks
        timer_zero = 1; tick_1hz = 1; step();
        timer_zero = 0; tick_1hz = 0; step();
        check("done_state", state, 4);
        check("done_beep_on", done_beep, 1);
        do_tick(2); do_tick(2);
        check("done_hold", state, 4);
        do_tick(2);
        check("done_to_idle", state, 0);
        check("done_beep_off", done_beep, 0);

        // Power wrap 1 -> 10, multi-bit key ignored
        repeat (6) press_power();
        check("power_min", power_level, 1);
        press_power();
        check("power_wrap", power_level, 10);
        loads.delete();
        keypad = 10'b0000000110; step();
        keypad = '0; step();
        check("multikey_loads", loads.size(), 0);
        check("multikey_state", state, 0);

        // Start from IDLE
        loads.delete();
        press_start();
        repeat (3) step();
`ifdef QUICK_START_EN
        check("qs_loads", loads.size(), 2);
        if (loads.size() == 2) begin
            check("qs_d0", loads[0], 3);
            check("qs_d1", loads[1], 0);
        end
        check("qs_state", state, 2);
        check("qs_ten", timer_en, 1);
        press_stop(); press_stop();
`else
        check("idle_start_ignored", state, 0);
        check("idle_start_loads", loads.size(), 0);
`endif

        // Randomized soak against the model
        for (int n = 0; n < 4000; n++) begin
            int r;
            tick_1hz = 0;
            clearn = ($urandom_range(0, 599) != 0);
            r = $urandom_range(0, 99);
            if (r < 4)       startn = ~startn;
            else if (r < 7)  stopn = ~stopn;
            else if (r < 11) powern = ~powern;
            else if (r < 19) begin
                case ($urandom_range(0, 3))
                    0, 1: keypad = '0;
                    2: keypad = 10'b1 << $urandom_range(0, 9);
                    default: keypad = (10'b1 << $urandom_range(0, 9)) | (10'b1 << $urandom_range(0, 9));
                endcase
            end
            else if (r < 21) door_closed = ~door_closed;
            else if (r < 30) tick_1hz = 1;
            else if (r < 32) timer_zero = ~timer_zero;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
